// File: rtl/text_addr_pipe.sv
// rtl/text_addr_pipe.sv - pixel to character-cell address pipeline with frame-synchronous scroll (optional cursor: TEXT_CURSOR_EN)
module text_addr_pipe #(
   parameter int CHAR_W = 9,
   parameter int CHAR_H = 16,
   parameter int COLS   = 70,
   parameter int ROWS   = 30,
   parameter int H_W    = 10,
   parameter int ADDR_W = 12
) (
   input  logic                      clk,
   input  logic                      rst_i,
   input  logic                      pix_valid_i,
   input  logic [H_W-1:0]            h_addr_i,
   input  logic [H_W-1:0]            v_addr_i,
   input  logic [$clog2(ROWS)-1:0]   scroll_top_i,
   input  logic                      scroll_load_i,
`ifdef TEXT_CURSOR_EN
   input  logic [$clog2(ROWS)-1:0]   cur_row_i,
   input  logic [$clog2(COLS)-1:0]   cur_col_i,
   output logic                      cursor_on_o,
`endif
   output logic                      scroll_ack_o,
   output logic [ADDR_W-1:0]         vgamem_addr_o,
   output logic [$clog2(CHAR_W)-1:0] x_in_o,
   output logic [$clog2(CHAR_H)-1:0] y_in_o,
   output logic                      blank_o,
   output logic                      out_valid_o
);

   localparam int RW = $clog2(ROWS);
   localparam int XW = $clog2(CHAR_W);
   localparam int YW = $clog2(CHAR_H);

   // Stage 1 state: running cell counters, last seen row, scroll registers
   logic [XW-1:0]  xc_q, xc_d;
   logic [YW-1:0]  yc_q, yc_d;
   logic [H_W-1:0] col_q, col_d;
   logic [H_W-1:0] row_q, row_d;
   logic [H_W-1:0] last_v_q, last_v_d;
   logic [RW-1:0]  top_q, top_d;
   logic [RW-1:0]  pend_q, pend_d;
   logic           pend_v_q, pend_v_d;
   logic           ack_d;
   logic           valid_s1_q;
   logic           commit;
   logic [RW-1:0]  top_req;

   // Stage 2 combinational mapping
   logic [RW:0]       phys_sum;
   logic [RW-1:0]     phys_row;
   logic [ADDR_W-1:0] row_x_cols;
   logic [ADDR_W-1:0] addr_s;
   logic              blank_s;

   assign commit  = pix_valid_i && (h_addr_i == '0) && (v_addr_i == '0);
   assign top_req = ({1'b0, scroll_top_i} >= (RW+1)'(ROWS)) ? RW'(ROWS - 1) : scroll_top_i;

   // Cell counters advance on valid pixels and resync on line/frame start
   always_comb begin
      xc_d     = xc_q;
      col_d    = col_q;
      yc_d     = yc_q;
      row_d    = row_q;
      last_v_d = last_v_q;
      if (pix_valid_i) begin
         last_v_d = v_addr_i;
         if (h_addr_i == '0) begin
            xc_d  = '0;
            col_d = '0;
         end else if (xc_q == XW'(CHAR_W - 1)) begin
            xc_d  = '0;
            col_d = col_q + 1'b1;
         end else begin
            xc_d = xc_q + 1'b1;
         end
         if (v_addr_i == '0) begin
            yc_d  = '0;
            row_d = '0;
         end else if (v_addr_i != last_v_q) begin
            if (yc_q == YW'(CHAR_H - 1)) begin
               yc_d  = '0;
               row_d = row_q + 1'b1;
            end else begin
               yc_d = yc_q + 1'b1;
            end
         end
      end
   end

   // Scroll request is held pending and only applied at the frame origin pixel
   always_comb begin
      top_d    = top_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      ack_d    = 1'b0;
      if (scroll_load_i) begin
         pend_d   = top_req;
         pend_v_d = 1'b1;
      end
      if (commit) begin
         if (scroll_load_i) begin
            top_d    = top_req;
            ack_d    = 1'b1;
            pend_v_d = 1'b0;
         end else if (pend_v_q) begin
            top_d    = pend_q;
            ack_d    = 1'b1;
            pend_v_d = 1'b0;
         end
      end
   end

   // Register stage 1 counters and scroll state
   always_ff @(posedge clk) begin
      if (rst_i) begin
         xc_q         <= '0;
         yc_q         <= '0;
         col_q        <= '0;
         row_q        <= '0;
         last_v_q     <= '0;
         top_q        <= '0;
         pend_q       <= '0;
         pend_v_q     <= 1'b0;
         scroll_ack_o <= 1'b0;
         valid_s1_q   <= 1'b0;
      end else begin
         xc_q         <= xc_d;
         yc_q         <= yc_d;
         col_q        <= col_d;
         row_q        <= row_d;
         last_v_q     <= last_v_d;
         top_q        <= top_d;
         pend_q       <= pend_d;
         pend_v_q     <= pend_v_d;
         scroll_ack_o <= ack_d;
         valid_s1_q   <= pix_valid_i;
      end
   end

   // Circular row mapping and row*COLS+col as a shift-add over the set bits of COLS
   always_comb begin
      phys_sum = {1'b0, row_q[RW-1:0]} + {1'b0, top_q};
      if (phys_sum >= (RW+1)'(ROWS)) begin
         phys_row = RW'(phys_sum - (RW+1)'(ROWS));
      end else begin
         phys_row = phys_sum[RW-1:0];
      end
      row_x_cols = '0;
      for (int b = 0; b < ADDR_W; b++) begin
         if (((COLS >> b) & 1) != 0) begin
            row_x_cols = row_x_cols + (ADDR_W'(phys_row) << b);
         end
      end
      blank_s = (col_q >= H_W'(COLS)) || (row_q >= H_W'(ROWS));
      addr_s  = blank_s ? '0 : (row_x_cols + ADDR_W'(col_q));
   end

   // Register stage 2 outputs
   always_ff @(posedge clk) begin
      if (rst_i) begin
         vgamem_addr_o <= '0;
         x_in_o        <= '0;
         y_in_o        <= '0;
         blank_o       <= 1'b0;
         out_valid_o   <= 1'b0;
      end else begin
         vgamem_addr_o <= addr_s;
         x_in_o        <= xc_q;
         y_in_o        <= yc_q;
         blank_o       <= blank_s;
         out_valid_o   <= valid_s1_q;
      end
   end

`ifdef TEXT_CURSOR_EN
   localparam int CW = $clog2(COLS);
   logic [4:0] blink_cnt_q;
   logic       blink_q;
   logic       cursor_s;

   assign cursor_s = (phys_row == cur_row_i)
                  && (col_q == {{(H_W-CW){1'b0}}, cur_col_i})
                  && (yc_q >= YW'(CHAR_H - 2))
                  && blink_q && !blank_s;

   // Blink phase flips once every 32 frame origins
   always_ff @(posedge clk) begin
      if (rst_i) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
         cursor_on_o <= 1'b0;
      end else begin
         if (commit) begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
            if (blink_cnt_q == 5'd31) begin
               blink_q <= ~blink_q;
            end
         end
         cursor_on_o <= cursor_s;
      end
   end
`endif

endmodule

// File: tb/tb_text_addr_pipe.sv
// tb/tb_text_addr_pipe.sv - directed self-checking bench for text_addr_pipe
module tb_text_addr_pipe;

   logic        clk = 1'b0;
   logic        rst_i, pix_valid_i, scroll_load_i;
   logic [9:0]  h_addr_i, v_addr_i;
   logic [4:0]  scroll_top_i;
   logic        scroll_ack_o, blank_o, out_valid_o;
   logic [11:0] vgamem_addr_o;
   logic [3:0]  x_in_o, y_in_o;
`ifdef TEXT_CURSOR_EN
   logic [4:0]  cur_row_i = 5'd2;
   logic [6:0]  cur_col_i = 7'd4;
   logic        cursor_on_o;
`endif

   int n_run   = 0;
   int n_fail  = 0;
   int ack_cnt = 0;

   always #5 clk = ~clk;

   text_addr_pipe dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .pix_valid_i   (pix_valid_i),
      .h_addr_i      (h_addr_i),
      .v_addr_i      (v_addr_i),
      .scroll_top_i  (scroll_top_i),
      .scroll_load_i (scroll_load_i),
`ifdef TEXT_CURSOR_EN
      .cur_row_i     (cur_row_i),
      .cur_col_i     (cur_col_i),
      .cursor_on_o   (cursor_on_o),
`endif
      .scroll_ack_o  (scroll_ack_o),
      .vgamem_addr_o (vgamem_addr_o),
      .x_in_o        (x_in_o),
      .y_in_o        (y_in_o),
      .blank_o       (blank_o),
      .out_valid_o   (out_valid_o)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_run++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pixel-clock step; outputs afterwards describe the pixel given one call earlier
   task automatic px(input logic vld, input int v, input int h);
      pix_valid_i = vld;
      v_addr_i    = 10'(v);
      h_addr_i    = 10'(h);
      @(posedge clk);
      #1;
      scroll_load_i = 1'b0;
      if (scroll_ack_o) ack_cnt++;
   endtask

   task automatic load(input int top);
      scroll_top_i  = 5'(top);
      scroll_load_i = 1'b1;
   endtask

   initial begin
      int prev_vld, prev_h, vld, h, pe;
      rst_i = 1'b1; pix_valid_i = 1'b0; scroll_load_i = 1'b0;
      scroll_top_i = '0; h_addr_i = '0; v_addr_i = '0;

      // reset
      for (int i = 0; i < 3; i++) px(1, 5, 5);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_addr", vgamem_addr_o, 0);
      chk("rst_x", x_in_o, 0);
      chk("rst_y", y_in_o, 0);
      chk("rst_blank", blank_o, 0);
      chk("rst_ack", scroll_ack_o, 0);
      rst_i = 1'b0;

      // first line, two cells
      for (int hh = 0; hh <= 18; hh++) begin
         px(hh < 18, 0, hh);
         if (hh > 0) begin
            chk("l0_addr", vgamem_addr_o, (hh - 1) / 9);
            chk("l0_x", x_in_o, (hh - 1) % 9);
            chk("l0_y", y_in_o, 0);
            chk("l0_blank", blank_o, 0);
            chk("l0_valid", out_valid_o, 1);
         end
      end

      // frame scan with short lines, then the last line in full
      for (int v = 0; v < 479; v++) begin
         px(1, v, 0);
         if (v == 17) begin
            chk("v16_addr", vgamem_addr_o, 70);
            chk("v16_y", y_in_o, 0);
         end
         if (v == 34) begin
            chk("v33_addr", vgamem_addr_o, 140);
            chk("v33_y", y_in_o, 1);
         end
      end
      for (int hh = 0; hh <= 631; hh++) begin
         px(1, 479, hh);
         if (hh == 630) begin
            chk("h629_addr", vgamem_addr_o, 2099);
            chk("h629_x", x_in_o, 8);
            chk("h629_y", y_in_o, 15);
            chk("h629_blank", blank_o, 0);
         end
         if (hh == 631) begin
            chk("h630_blank", blank_o, 1);
            chk("h630_addr", vgamem_addr_o, 0);
            chk("h630_x", x_in_o, 0);
         end
      end
      px(0, 479, 632);

      // scroll to 5 requested mid-frame
      ack_cnt = 0;
      for (int v = 0; v <= 479; v++) begin
         if (v == 200) load(5);
         px(1, v, 0);
         if (v == 201) chk("scr_hold_addr", vgamem_addr_o, 840);
      end
      chk("scr_no_early_ack", ack_cnt, 0);
      px(1, 0, 0);
      chk("scr_ack", scroll_ack_o, 1);
      px(1, 0, 1);
      chk("scr_top_addr", vgamem_addr_o, 350);
      chk("scr_ack_pulse", scroll_ack_o, 0);
      for (int v = 1; v <= 401; v++) begin
         px(1, v, 0);
         if (v == 385) chk("scr_r24_addr", vgamem_addr_o, 2030);
         if (v == 401) begin
            chk("scr_r25_addr", vgamem_addr_o, 0);
            chk("scr_r25_blank", blank_o, 0);
         end
      end

      // overwrite before commit, clamp, load coinciding with commit
      ack_cnt = 0;
      for (int v = 402; v <= 479; v++) begin
         if (v == 410) load(3);
         if (v == 420) load(7);
         px(1, v, 0);
      end
      px(1, 0, 0);
      px(1, 1, 0);
      chk("ovw_addr", vgamem_addr_o, 490);
      chk("ovw_acks", ack_cnt, 1);
      for (int v = 2; v <= 479; v++) begin
         if (v == 100) load(31);
         px(1, v, 0);
      end
      px(1, 0, 0);
      px(1, 1, 0);
      chk("clamp_addr", vgamem_addr_o, 2030);
      for (int v = 2; v <= 479; v++) px(1, v, 0);
      load(2);
      px(1, 0, 0);
      chk("coin_ack", scroll_ack_o, 1);
      px(1, 1, 0);
      chk("coin_addr", vgamem_addr_o, 140);
      chk("scr_acks", ack_cnt, 3);

      // valid gap mid-line
      prev_vld = 0; prev_h = 0;
      for (int k = 0; k <= 26; k++) begin
         vld = (k >= 13 && k < 18) ? 0 : 1;
         h   = (k < 13) ? k : ((k < 18) ? 999 : k - 5);
         px(vld[0], 0, h);
         if (k > 0) begin
            chk("gap_valid", out_valid_o, prev_vld);
            if (prev_vld != 0) begin
               chk("gap_addr", vgamem_addr_o, 140 + prev_h / 9);
               chk("gap_x", x_in_o, prev_h % 9);
            end
         end
         prev_vld = vld; prev_h = h;
      end

      // reset between load and commit discards the request
      for (int v = 1; v <= 30; v++) begin
         if (v == 30) load(9);
         px(1, v, 0);
      end
      rst_i = 1'b1;
      px(0, 0, 0);
      px(0, 0, 0);
      rst_i = 1'b0;
      ack_cnt = 0;
      px(1, 0, 0);
      px(1, 1, 0);
      chk("rstp_addr", vgamem_addr_o, 0);
      chk("rstp_acks", ack_cnt, 0);

`ifdef TEXT_CURSOR_EN
      pe = -1;
      for (int v = 0; v <= 48; v++) begin
         for (int hh = 0; hh <= 50; hh++) begin
            px(1, v, hh);
            if (pe >= 0) chk("cursor", cursor_on_o, pe);
            pe = (v >= 44) ? (((v == 46 || v == 47) && hh >= 36 && hh <= 44) ? 1 : 0) : -1;
         end
      end
`else
      pe = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
